// File: rtl/forward_sequencer.sv
// forward_sequencer
//   Layer-by-layer controller for the `forward` datapath. Accepts one input
//   sample, then issues per-layer configuration to `forward` for layers
//   0..LAYER_MAX-1. Each layer gets a previous/current neuron count, a layer
//   number and, on layer 0 only, the start inputs. The sequencer consumes each
//   layer's outputs and returns the last layer's outputs together with a sticky
//   overflow flag. The weight store lives outside this block and is indexed by
//   fw_layer_number.
//
//   Optional build macro: SEQ_TIMEOUT_EN. It adds the TIMEOUT_CYCLES parameter
//   and the timeout_err output port. A watchdog counts cycles in ISSUE and
//   WAIT, and every handshake restarts it. When the count reaches
//   TIMEOUT_CYCLES, the run is abandoned and the block returns to IDLE.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   sample / _valid / _ready     input activations (one lane per neuron)
//   cfg_wr_en/_addr/_data        neuron-count table write (entry 0 = input layer)
//   cfg_error                    one-cycle pulse after a rejected table write
//   fw_curr_neurons*             neuron count of the layer being computed
//   fw_prev_neurons*             neuron count of the layer feeding it
//   fw_start_inputs*             latched sample, offered on layer 0 only
//   fw_layer_number*             layer index, also addresses the weight store
//   fw_outputs/_overflow/_valid/_ready   per-layer results from `forward`
//   result/_overflow/_valid/_ready       final-layer result to the requester
//   busy                         high whenever the sequencer is not IDLE
//   timeout_err                  (SEQ_TIMEOUT_EN only) watchdog expiry pulse
module forward_sequencer #(
`ifdef SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES      = 1024,
`endif
  parameter int NEURON_NUM          = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int LAYER_ADDR_WIDTH    = 2,
  parameter int LAYER_MAX           = 3,
  localparam int CNT_W              = $clog2(NEURON_NUM) + 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    sample,
  input  logic                                      sample_valid,
  output logic                                      sample_ready,
  input  logic                                      cfg_wr_en,
  input  logic [LAYER_ADDR_WIDTH-1:0]               cfg_wr_addr,
  input  logic [CNT_W-1:0]                          cfg_wr_data,
  output logic                                      cfg_error,
  output logic [CNT_W-1:0]                          fw_curr_neurons,
  output logic                                      fw_curr_neurons_valid,
  input  logic                                      fw_curr_neurons_ready,
  output logic [CNT_W-1:0]                          fw_prev_neurons,
  output logic                                      fw_prev_neurons_valid,
  input  logic                                      fw_prev_neurons_ready,
  output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    fw_start_inputs,
  output logic                                      fw_start_inputs_valid,
  input  logic                                      fw_start_inputs_ready,
  output logic [LAYER_ADDR_WIDTH-1:0]               fw_layer_number,
  output logic                                      fw_layer_number_valid,
  input  logic                                      fw_layer_number_ready,
  input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] fw_outputs,
  input  logic                                      fw_overflow,
  input  logic                                      fw_outputs_valid,
  output logic                                      fw_outputs_ready,
  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] result,
  output logic                                      result_overflow,
  output logic                                      result_valid,
  input  logic                                      result_ready,
  output logic                                      busy
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic                                      timeout_err
`endif
);

  localparam logic [CNT_W-1:0] NEURON_NUM_C = CNT_W'(NEURON_NUM);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                                    state;
  state_t                                    state_next;
  logic                                      armed;
  logic [LAYER_ADDR_WIDTH-1:0]               layer;
  logic [LAYER_ADDR_WIDTH-1:0]               layer_plus1;
  logic [CNT_W-1:0]                          size_tab [LAYER_MAX+1];
  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    sample_q;
  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] result_q;
  logic                                      sticky_ovf;
  logic curr_pend, prev_pend, start_pend, lnum_pend;
  logic curr_hs, prev_hs, start_hs, lnum_hs, out_hs;
  logic sample_hs, issue_done, last_layer, cfg_ok, timeout_hit;

  assign layer_plus1 = layer + LAYER_ADDR_WIDTH'(1);
  assign last_layer  = (int'(layer) == LAYER_MAX - 1);

  // armed stays low for the first cycle after reset so that sample_ready
  // shows its reset value even when reset lands in the middle of a run.
  assign sample_hs = (state == S_IDLE) && armed && sample_valid;
  assign curr_hs   = curr_pend  && fw_curr_neurons_ready;
  assign prev_hs   = prev_pend  && fw_prev_neurons_ready;
  assign start_hs  = start_pend && fw_start_inputs_ready;
  assign lnum_hs   = lnum_pend  && fw_layer_number_ready;
  assign out_hs    = (state == S_WAIT) && fw_outputs_valid;

  // The issue phase is finished once no channel is still pending after the
  // handshakes of this cycle. Channels may complete in the same cycle or in
  // separate cycles.
  assign issue_done = !(curr_pend  && !curr_hs)  && !(prev_pend && !prev_hs) &&
                      !(start_pend && !start_hs) && !(lnum_pend && !lnum_hs);

  assign cfg_ok = (state == S_IDLE) &&
                  (int'(cfg_wr_data) >= 1) && (int'(cfg_wr_data) <= NEURON_NUM) &&
                  (int'(cfg_wr_addr) <= LAYER_MAX);

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             any_hs;
  logic             tmo_active;

  assign any_hs      = curr_hs || prev_hs || start_hs || lnum_hs || out_hs;
  assign tmo_active  = (state == S_ISSUE) || (state == S_WAIT);
  assign timeout_hit = tmo_active && !any_hs && (int'(tmo_cnt) == TIMEOUT_CYCLES - 1);
  assign timeout_err = timeout_hit;

  always_ff @(posedge clk) begin
    if (rst || !tmo_active || any_hs) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (sample_hs)    state_next = S_ISSUE;
      S_ISSUE: if (issue_done)   state_next = S_WAIT;
      S_WAIT:  if (out_hs)       state_next = last_layer ? S_DONE : S_ISSUE;
      S_DONE:  if (result_ready) state_next = S_IDLE;
      default:                   state_next = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed      <= 1'b0;
      layer      <= '0;
      sample_q   <= '0;
      result_q   <= '0;
      sticky_ovf <= 1'b0;
      cfg_error  <= 1'b0;
      curr_pend  <= 1'b0;
      prev_pend  <= 1'b0;
      start_pend <= 1'b0;
      lnum_pend  <= 1'b0;
      for (int i = 0; i <= LAYER_MAX; i++) begin
        size_tab[i] <= NEURON_NUM_C;
      end
    end else begin
      armed     <= 1'b1;
      cfg_error <= cfg_wr_en && !cfg_ok;
      if (cfg_wr_en && cfg_ok) begin
        size_tab[cfg_wr_addr] <= cfg_wr_data;
      end
      if (sample_hs) begin
        sample_q   <= sample;
        sticky_ovf <= 1'b0;
        layer      <= '0;
      end
      if (out_hs) begin
        result_q   <= fw_outputs;
        sticky_ovf <= sticky_ovf | fw_overflow;
        if (!last_layer) begin
          layer <= layer_plus1;
        end
      end
      // Each channel's valid is raised on entry to ISSUE and dropped the
      // cycle after its own handshake. Start inputs are offered only when
      // entering from IDLE, which is always layer 0.
      if (timeout_hit) begin
        curr_pend  <= 1'b0;
        prev_pend  <= 1'b0;
        start_pend <= 1'b0;
        lnum_pend  <= 1'b0;
      end else if ((state_next == S_ISSUE) && (state != S_ISSUE)) begin
        curr_pend  <= 1'b1;
        prev_pend  <= 1'b1;
        lnum_pend  <= 1'b1;
        start_pend <= (state == S_IDLE);
      end else begin
        if (curr_hs)  curr_pend  <= 1'b0;
        if (prev_hs)  prev_pend  <= 1'b0;
        if (start_hs) start_pend <= 1'b0;
        if (lnum_hs)  lnum_pend  <= 1'b0;
      end
    end
  end

  always_comb begin
    sample_ready          = (state == S_IDLE) && armed;
    busy                  = (state != S_IDLE);
    fw_outputs_ready      = (state == S_WAIT);
    result_valid          = (state == S_DONE);
    result_overflow       = (state == S_DONE) && sticky_ovf;
    result                = result_q;
    fw_curr_neurons_valid = curr_pend;
    fw_prev_neurons_valid = prev_pend;
    fw_start_inputs_valid = start_pend;
    fw_layer_number_valid = lnum_pend;
    fw_prev_neurons       = size_tab[layer];
    fw_curr_neurons       = size_tab[layer_plus1];
    fw_layer_number       = layer;
    fw_start_inputs       = sample_q;
  end

endmodule

// File: tb/tb_forward_sequencer.sv
// tb_forward_sequencer
//   Directed bench for forward_sequencer in its default build. A small stub
//   stands in for `forward`. For each lane, the stub returns its previous
//   input plus one. With three layers, every lane of the final result is
//   therefore the sample value plus three. The stub can also flag overflow
//   on layer 1.
module tb_forward_sequencer;

  localparam int NN = 5;
  localparam int OW = 10;
  localparam int AW = 9;
  localparam int LW = 2;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NN*AW-1:0]  sample;
  logic              sample_valid;
  logic              sample_ready;
  logic              cfg_wr_en;
  logic [LW-1:0]     cfg_wr_addr;
  logic [CW-1:0]     cfg_wr_data;
  logic              cfg_error;
  logic [CW-1:0]     fw_curr_neurons;
  logic              fw_curr_neurons_valid;
  logic              fw_curr_neurons_ready;
  logic [CW-1:0]     fw_prev_neurons;
  logic              fw_prev_neurons_valid;
  logic              fw_prev_neurons_ready;
  logic [NN*AW-1:0]  fw_start_inputs;
  logic              fw_start_inputs_valid;
  logic              fw_start_inputs_ready;
  logic [LW-1:0]     fw_layer_number;
  logic              fw_layer_number_valid;
  logic              fw_layer_number_ready;
  logic [NN*OW-1:0]  fw_outputs;
  logic              fw_overflow;
  logic              fw_outputs_valid;
  logic              fw_outputs_ready;
  logic [NN*OW-1:0]  result;
  logic              result_overflow;
  logic              result_valid;
  logic              result_ready;
  logic              busy;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  forward_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .sample                (sample),
    .sample_valid          (sample_valid),
    .sample_ready          (sample_ready),
    .cfg_wr_en             (cfg_wr_en),
    .cfg_wr_addr           (cfg_wr_addr),
    .cfg_wr_data           (cfg_wr_data),
    .cfg_error             (cfg_error),
    .fw_curr_neurons       (fw_curr_neurons),
    .fw_curr_neurons_valid (fw_curr_neurons_valid),
    .fw_curr_neurons_ready (fw_curr_neurons_ready),
    .fw_prev_neurons       (fw_prev_neurons),
    .fw_prev_neurons_valid (fw_prev_neurons_valid),
    .fw_prev_neurons_ready (fw_prev_neurons_ready),
    .fw_start_inputs       (fw_start_inputs),
    .fw_start_inputs_valid (fw_start_inputs_valid),
    .fw_start_inputs_ready (fw_start_inputs_ready),
    .fw_layer_number       (fw_layer_number),
    .fw_layer_number_valid (fw_layer_number_valid),
    .fw_layer_number_ready (fw_layer_number_ready),
    .fw_outputs            (fw_outputs),
    .fw_overflow           (fw_overflow),
    .fw_outputs_valid      (fw_outputs_valid),
    .fw_outputs_ready      (fw_outputs_ready),
    .result                (result),
    .result_overflow       (result_overflow),
    .result_valid          (result_valid),
    .result_ready          (result_ready),
    .busy                  (busy)
  );

  // The stub for `forward` holds the activations of the current layer. It
  // captures them from the start inputs on layer 0 and from its own outputs
  // after each accepted layer.
  logic [NN*OW-1:0] stub_acts;
  logic [LW-1:0]    stub_layer;
  logic             stub_ovf_en;
  logic             stub_out_valid;

  always @(posedge clk) begin
    if (fw_start_inputs_valid && fw_start_inputs_ready) begin
      for (int i = 0; i < NN; i++) begin
        stub_acts[i*OW +: OW] <= OW'(fw_start_inputs[i*AW +: AW]);
      end
    end else if (fw_outputs_valid && fw_outputs_ready) begin
      stub_acts <= fw_outputs;
    end
    if (fw_layer_number_valid && fw_layer_number_ready) begin
      stub_layer <= fw_layer_number;
    end
  end

  always_comb begin
    fw_outputs = '0;
    for (int i = 0; i < NN; i++) begin
      fw_outputs[i*OW +: OW] = stub_acts[i*OW +: OW] + OW'(1);
    end
  end

  assign fw_overflow      = stub_ovf_en && (stub_layer == 2'd1);
  assign fw_outputs_valid = stub_out_valid;

  // A record of what the sequencer issued for each layer.
  int log_layer[$];
  int log_prev[$];
  int log_curr[$];
  int log_start[$];

  always @(posedge clk) begin
    if (fw_layer_number_valid && fw_layer_number_ready) begin
      log_layer.push_back(int'(fw_layer_number));
      log_prev.push_back(int'(fw_prev_neurons));
      log_curr.push_back(int'(fw_curr_neurons));
    end
    if (fw_start_inputs_valid && fw_start_inputs_ready) begin
      log_start.push_back(int'(fw_layer_number));
    end
  end

  function automatic logic [NN*AW-1:0] pack_act(input int a0, input int a1, input int a2,
                                                input int a3, input int a4);
    int               v[NN];
    logic [NN*AW-1:0] p;
    v = '{a0, a1, a2, a3, a4};
    p = '0;
    for (int i = 0; i < NN; i++) p[i*AW +: AW] = AW'(v[i]);
    return p;
  endfunction

  function automatic logic [NN*OW-1:0] pack_out(input int a0, input int a1, input int a2,
                                                input int a3, input int a4);
    int               v[NN];
    logic [NN*OW-1:0] p;
    v = '{a0, a1, a2, a3, a4};
    p = '0;
    for (int i = 0; i < NN; i++) p[i*OW +: OW] = OW'(v[i]);
    return p;
  endfunction

  function automatic logic [9:0] ctrl_bus();
    return {fw_curr_neurons_valid, fw_prev_neurons_valid, fw_start_inputs_valid,
            fw_layer_number_valid, sample_ready, fw_outputs_ready, cfg_error,
            busy, result_valid, result_overflow};
  endfunction

  function automatic logic [3:0] valid_bus();
    return {fw_layer_number_valid, fw_curr_neurons_valid, fw_prev_neurons_valid,
            fw_start_inputs_valid};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    log_layer.delete();
    log_prev.delete();
    log_curr.delete();
    log_start.delete();
  endtask

  // Presents a sample and returns 1 time unit after the edge that accepted it.
  task automatic applyStimulus(input logic [NN*AW-1:0] s);
    bit seen;
    seen         = 1'b0;
    sample       = s;
    sample_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (sample_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) checkOutput("sample_accept_timeout", 64'(sample_ready), 64'd1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!result_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (!result_valid) checkOutput("result_timeout", 64'(result_valid), 64'd1);
  endtask

  task automatic finishRun(input string tag);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    checkOutput({tag, "_ready_after"}, 64'(sample_ready), 64'd1);
    checkOutput({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  task automatic cfgWrite(input string tag, input int addr, input int data,
                          input logic exp_err);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = LW'(addr);
    cfg_wr_data = CW'(data);
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
    checkOutput({tag, "_pulse"}, 64'(cfg_error), 64'(exp_err));
    @(posedge clk);
    #1;
    checkOutput({tag, "_clear"}, 64'(cfg_error), 64'd0);
  endtask

  task automatic checkSizes(input string tag, input int p0, input int p1, input int p2,
                            input int c0, input int c1, input int c2);
    int ep[3];
    int ec[3];
    ep = '{p0, p1, p2};
    ec = '{c0, c1, c2};
    checkOutput({tag, "_layer_count"}, 64'(log_layer.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s_layer%0d_num", tag, i),
                  64'((i < log_layer.size()) ? log_layer[i] : -1), 64'(i));
      checkOutput($sformatf("%s_layer%0d_prev", tag, i),
                  64'((i < log_prev.size()) ? log_prev[i] : -1), 64'(ep[i]));
      checkOutput($sformatf("%s_layer%0d_curr", tag, i),
                  64'((i < log_curr.size()) ? log_curr[i] : -1), 64'(ec[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst                   = 1'b1;
    sample                = '0;
    sample_valid          = 1'b0;
    cfg_wr_en             = 1'b0;
    cfg_wr_addr           = '0;
    cfg_wr_data           = '0;
    fw_curr_neurons_ready = 1'b1;
    fw_prev_neurons_ready = 1'b1;
    fw_start_inputs_ready = 1'b1;
    fw_layer_number_ready = 1'b1;
    result_ready          = 1'b0;
    stub_ovf_en           = 1'b0;
    stub_out_valid        = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", 64'(ctrl_bus()), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_prev", 64'(fw_prev_neurons), 64'd5);
    checkOutput("reset_curr", 64'(fw_curr_neurons), 64'd5);
    rst = 1'b0;

    // Default sizes, all peers ready: minimum latency, layers in order
    clearLogs();
    applyStimulus(pack_act(5, 4, 3, 2, 1));
    waitResult(lat);
    checkOutput("t1_latency", 64'(lat), 64'd7);
    checkOutput("t1_result", 64'(result), 64'(pack_out(8, 7, 6, 5, 4)));
    checkOutput("t1_overflow", 64'(result_overflow), 64'd0);
    checkSizes("t1", 5, 5, 5, 5, 5, 5);
    checkOutput("t1_start_count", 64'(log_start.size()), 64'd1);
    checkOutput("t1_start_layer", 64'((log_start.size() > 0) ? log_start[0] : -1), 64'd0);
    finishRun("t1");

    // Programmed sizes
    cfgWrite("t2_wr1", 1, 3, 1'b0);
    cfgWrite("t2_wr2", 2, 2, 1'b0);
    clearLogs();
    applyStimulus(pack_act(1, 2, 3, 4, 5));
    waitResult(lat);
    checkOutput("t2_result", 64'(result), 64'(pack_out(4, 5, 6, 7, 8)));
    checkSizes("t2", 5, 3, 2, 3, 2, 5);
    finishRun("t2");

    // Staggered readies on layer 0: layer/start at +1, prev at +2, curr at +3
    fw_curr_neurons_ready = 1'b0;
    fw_prev_neurons_ready = 1'b0;
    fw_start_inputs_ready = 1'b0;
    fw_layer_number_ready = 1'b0;
    applyStimulus(pack_act(511, 0, 1, 2, 3));
    checkOutput("t3_valids_entry", 64'(valid_bus()), 64'b1111);
    fw_layer_number_ready = 1'b1;
    fw_start_inputs_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t3_valids_step1", 64'(valid_bus()), 64'b0110);
    checkOutput("t3_wait_step1", 64'(fw_outputs_ready), 64'd0);
    fw_layer_number_ready = 1'b0;
    fw_start_inputs_ready = 1'b0;
    fw_prev_neurons_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t3_valids_step2", 64'(valid_bus()), 64'b0100);
    checkOutput("t3_wait_step2", 64'(fw_outputs_ready), 64'd0);
    fw_prev_neurons_ready = 1'b0;
    fw_curr_neurons_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t3_valids_step3", 64'(valid_bus()), 64'b0000);
    checkOutput("t3_wait_step3", 64'(fw_outputs_ready), 64'd1);
    fw_prev_neurons_ready = 1'b1;
    fw_start_inputs_ready = 1'b1;
    fw_layer_number_ready = 1'b1;
    waitResult(lat);
    checkOutput("t3_result", 64'(result), 64'(pack_out(514, 3, 4, 5, 6)));
    finishRun("t3");

    // Overflow on layer 1 is sticky for the run and cleared for the next
    stub_ovf_en = 1'b1;
    applyStimulus(pack_act(0, 0, 0, 0, 0));
    waitResult(lat);
    checkOutput("t4_result", 64'(result), 64'(pack_out(3, 3, 3, 3, 3)));
    checkOutput("t4_overflow_set", 64'(result_overflow), 64'd1);
    finishRun("t4a");
    stub_ovf_en = 1'b0;
    applyStimulus(pack_act(9, 8, 7, 6, 5));
    waitResult(lat);
    checkOutput("t4_result_next", 64'(result), 64'(pack_out(12, 11, 10, 9, 8)));
    checkOutput("t4_overflow_clear", 64'(result_overflow), 64'd0);
    finishRun("t4b");

    // Rejected writes: zero, above NEURON_NUM, and while busy
    cfgWrite("t5_zero", 1, 0, 1'b1);
    cfgWrite("t5_six", 2, 6, 1'b1);
    applyStimulus(pack_act(1, 1, 1, 1, 1));
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 2'd2;
    cfg_wr_data = 4'd1;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
    checkOutput("t5_busy_pulse", 64'(cfg_error), 64'd1);
    waitResult(lat);
    checkOutput("t5_busy_result", 64'(result), 64'(pack_out(4, 4, 4, 4, 4)));
    finishRun("t5a");

    // Write to the output-layer entry in the same cycle as sample acceptance
    clearLogs();
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 2'd3;
    cfg_wr_data = 4'd1;
    applyStimulus(pack_act(2, 2, 2, 2, 2));
    cfg_wr_en = 1'b0;
    checkOutput("t5_accept_wr_err", 64'(cfg_error), 64'd0);
    waitResult(lat);
    checkSizes("t5", 5, 3, 2, 3, 2, 1);
    checkOutput("t5_result", 64'(result), 64'(pack_out(5, 5, 5, 5, 5)));
    finishRun("t5b");

    // Reset in WAIT aborts the run and restores every reset value
    applyStimulus(pack_act(3, 3, 3, 3, 3));
    for (int k = 0; k < 20; k++) begin
      if (fw_outputs_ready) break;
      @(negedge clk);
    end
    checkOutput("t6_reached_wait", 64'(fw_outputs_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_ctrl", 64'(ctrl_bus()), 64'd0);
    checkOutput("t6_result", 64'(result), 64'd0);
    checkOutput("t6_prev", 64'(fw_prev_neurons), 64'd5);
    checkOutput("t6_curr", 64'(fw_curr_neurons), 64'd5);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (sample_ready) break;
    end
    checkOutput("t6_ready_again", 64'(sample_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
